// File: rtl/casas_update_ctrl.sv
// rtl/casas_update_ctrl.sv - write-side controller for the houses (casas) register
//
// Purpose: on a frog arrival at the top row, decide fill vs. death, write the
// updated houses value, verify the readback, and run the level-complete
// (win -> hold -> clear) sequence once every house is occupied.
//
// Ports:
//   SC_CasasCTRL_CLOCK_50           in   system clock
//   SC_CasasCTRL_RESET_InHigh       in   asynchronous reset, active-high
//   SC_CasasCTRL_arrive_InLow       in   arrival strobe, active-low
//   SC_CasasCTRL_frogPos_InBUS      in   frog column, expected one-hot
//   SC_CasasCTRL_casas_InBUS        in   current houses register contents
//   SC_CasasCTRL_dataVariada_OutBUS out  updated value for the houses register
//   SC_CasasCTRL_loadVariado_OutLow out  load strobe, active-low
//   SC_CasasCTRL_clear_OutLow       out  clear strobe, active-low
//   SC_CasasCTRL_win_OutHigh        out  all houses filled pulse
//   SC_CasasCTRL_death_OutHigh      out  invalid / occupied landing pulse
//   SC_CasasCTRL_error_OutHigh      out  readback mismatch pulse
//   SC_CasasCTRL_busy_OutHigh       out  high whenever the FSM is not idle
//   SC_CasasCTRL_level_OutBUS       out  completed-level count
module casas_update_ctrl #(
   parameter int CASAS_DATAWIDTH = 8,
   parameter int WIN_HOLD        = 50,
   parameter int LEVEL_WIDTH     = 4
) (
   input  logic                       SC_CasasCTRL_CLOCK_50,
   input  logic                       SC_CasasCTRL_RESET_InHigh,
   input  logic                       SC_CasasCTRL_arrive_InLow,
   input  logic [CASAS_DATAWIDTH-1:0] SC_CasasCTRL_frogPos_InBUS,
   input  logic [CASAS_DATAWIDTH-1:0] SC_CasasCTRL_casas_InBUS,
   output logic [CASAS_DATAWIDTH-1:0] SC_CasasCTRL_dataVariada_OutBUS,
   output logic                       SC_CasasCTRL_loadVariado_OutLow,
   output logic                       SC_CasasCTRL_clear_OutLow,
   output logic                       SC_CasasCTRL_win_OutHigh,
   output logic                       SC_CasasCTRL_death_OutHigh,
   output logic                       SC_CasasCTRL_error_OutHigh,
   output logic                       SC_CasasCTRL_busy_OutHigh,
   output logic [LEVEL_WIDTH-1:0]     SC_CasasCTRL_level_OutBUS
);

   localparam int CW = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
   localparam logic [CASAS_DATAWIDTH-1:0] ONE     = CASAS_DATAWIDTH'(1);
   localparam logic [CW-1:0]              HOLD_MAX = CW'(WIN_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_WRITE, S_VERIFY, S_DEATH, S_WIN_HOLD, S_CLEAR
   } state_t;

   state_t                     r_state;
   logic [CASAS_DATAWIDTH-1:0] r_frog;
   logic [CASAS_DATAWIDTH-1:0] r_casas;
   logic [CASAS_DATAWIDTH-1:0] r_next;
   logic [CW-1:0]              r_hold_cnt;
   logic [CASAS_DATAWIDTH-1:0] r_data;
   logic                       r_load_n;
   logic                       r_clear_n;
   logic                       r_win;
   logic                       r_death;
   logic                       r_error;
   logic                       r_busy;
   logic [LEVEL_WIDTH-1:0]     r_level;

   logic w_onehot;
   logic w_valid;
   logic w_full;

   // x & (x-1) clears the lowest set bit; zero result with x!=0 means exactly one bit.
   assign w_onehot = (r_frog != '0) && ((r_frog & (r_frog - ONE)) == '0);
   assign w_valid  = w_onehot && ((r_frog & r_casas) == '0);
   assign w_full   = &r_next;

   always_ff @(posedge SC_CasasCTRL_CLOCK_50 or posedge SC_CasasCTRL_RESET_InHigh) begin
      if (SC_CasasCTRL_RESET_InHigh) begin
         r_state    <= S_IDLE;
         r_frog     <= '0;
         r_casas    <= '0;
         r_next     <= '0;
         r_hold_cnt <= '0;
         r_data     <= '0;
         r_load_n   <= 1'b1;
         r_clear_n  <= 1'b1;
         r_win      <= 1'b0;
         r_death    <= 1'b0;
         r_error    <= 1'b0;
         r_busy     <= 1'b0;
         r_level    <= '0;
      end else begin
         // Strobes default to inactive so every pulse lasts exactly one cycle.
         r_load_n  <= 1'b1;
         r_clear_n <= 1'b1;
         r_win     <= 1'b0;
         r_death   <= 1'b0;
         r_error   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!SC_CasasCTRL_arrive_InLow) begin
                  r_frog  <= SC_CasasCTRL_frogPos_InBUS;
                  r_casas <= SC_CasasCTRL_casas_InBUS;
                  r_busy  <= 1'b1;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_valid) begin
                  r_next  <= r_casas | r_frog;
                  r_state <= S_WRITE;
               end else begin
                  r_state <= S_DEATH;
               end
            end
            S_DEATH: begin
               r_death <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_WRITE: begin
               r_data   <= r_next;
               r_load_n <= 1'b0;
               r_state  <= S_VERIFY;
            end
            S_VERIFY: begin
               if (SC_CasasCTRL_casas_InBUS != r_next) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_full) begin
                  r_win      <= 1'b1;
                  r_level    <= r_level + LEVEL_WIDTH'(1);
                  r_hold_cnt <= '0;
                  r_state    <= S_WIN_HOLD;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_WIN_HOLD: begin
               if (r_hold_cnt == HOLD_MAX) begin
                  r_state <= S_CLEAR;
               end else begin
                  r_hold_cnt <= r_hold_cnt + CW'(1);
               end
            end
            S_CLEAR: begin
               r_clear_n <= 1'b0;
               r_data    <= '0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign SC_CasasCTRL_dataVariada_OutBUS = r_data;
   assign SC_CasasCTRL_loadVariado_OutLow = r_load_n;
   assign SC_CasasCTRL_clear_OutLow       = r_clear_n;
   assign SC_CasasCTRL_win_OutHigh        = r_win;
   assign SC_CasasCTRL_death_OutHigh      = r_death;
   assign SC_CasasCTRL_error_OutHigh      = r_error;
   assign SC_CasasCTRL_busy_OutHigh       = r_busy;
   assign SC_CasasCTRL_level_OutBUS       = r_level;

endmodule

// File: tb/tb_casas_update_ctrl.sv
// tb/tb_casas_update_ctrl.sv - randomized self-checking bench for casas_update_ctrl
module tb_casas_update_ctrl;
   localparam int W  = 8;
   localparam int WH = 50;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          arrive_n;
   logic [W-1:0]  frog;
   logic [W-1:0]  casas;
   logic [W-1:0]  data;
   logic          load_n, clear_n, win, death, err, busy;
   logic [LW-1:0] level;

   casas_update_ctrl #(.CASAS_DATAWIDTH(W), .WIN_HOLD(WH), .LEVEL_WIDTH(LW)) dut (
      .SC_CasasCTRL_CLOCK_50          (clk),
      .SC_CasasCTRL_RESET_InHigh      (rst),
      .SC_CasasCTRL_arrive_InLow      (arrive_n),
      .SC_CasasCTRL_frogPos_InBUS     (frog),
      .SC_CasasCTRL_casas_InBUS       (casas),
      .SC_CasasCTRL_dataVariada_OutBUS(data),
      .SC_CasasCTRL_loadVariado_OutLow(load_n),
      .SC_CasasCTRL_clear_OutLow      (clear_n),
      .SC_CasasCTRL_win_OutHigh       (win),
      .SC_CasasCTRL_death_OutHigh     (death),
      .SC_CasasCTRL_error_OutHigh     (err),
      .SC_CasasCTRL_busy_OutHigh      (busy),
      .SC_CasasCTRL_level_OutBUS      (level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference state: houses register contents, last written data, level count.
   logic [W-1:0]  m_casas = '0;
   logic [W-1:0]  m_data  = '0;
   int            m_level = 0;

   task automatic check_idle(input string tag);
      check({tag, ".load"},  load_n,  1);
      check({tag, ".clear"}, clear_n, 1);
      check({tag, ".data"},  data,    0);
      check({tag, ".win"},   win,     0);
      check({tag, ".death"}, death,   0);
      check({tag, ".error"}, err,     0);
      check({tag, ".busy"},  busy,    0);
      check({tag, ".level"}, level,   0);
   endtask

   // One arrival. Called and returns at a negedge with the DUT idle.
   // stale: the houses register ignores the write. rst_at: cycle to reset in (-1 = none).
   task automatic run_txn(input logic [W-1:0] f, input bit stale, input int rst_at);
      logic [W-1:0] c0;
      logic [W-1:0] nxt;
      bit valid, win_e, err_e;
      int last_busy, window, exp_lvl;
      bit e_busy;
      c0        = m_casas;
      valid     = ($countones(f) == 1) && ((f & c0) == 0);
      nxt       = c0 | f;
      err_e     = valid && stale;
      win_e     = valid && !stale && (nxt == {W{1'b1}});
      last_busy = !valid ? 1 : (win_e ? 3 + WH : 2);
      window    = last_busy + 3;

      frog     = f;
      casas    = c0;
      arrive_n = 1'b0;
      @(posedge clk);
      for (int k = 0; k <= window; k++) begin
         @(negedge clk);
         arrive_n = 1'b1;
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check_idle("rst_mid");
            @(negedge clk);
            rst      = 1'b0;
            m_casas  = '0;
            m_data   = '0;
            m_level  = 0;
            casas    = '0;
            for (int j = 0; j < WH + 6; j++) begin
               @(negedge clk);
               check_idle("post_rst");
            end
            return;
         end
         e_busy  = (k <= last_busy);
         exp_lvl = (m_level + ((win_e && k >= 3) ? 1 : 0)) % (1 << LW);
         check("load",  load_n,  !(valid && k == 2));
         check("clear", clear_n, !(win_e && k == 4 + WH));
         check("death", death,   !valid && k == 2);
         check("error", err,     err_e && k == 3);
         check("win",   win,     win_e && k == 3);
         check("busy",  busy,    e_busy);
         check("level", level,   exp_lvl);
         if (win_e && k >= 4 + WH)   check("data", data, 0);
         else if (valid && k >= 2)   check("data", data, nxt);
         else                        check("data", data, m_data);
         // Houses register behaviour: loads on the write, clears on the clear.
         if (valid && !stale && k == 2) casas = nxt;
         if (win_e && k == 4 + WH)      casas = '0;
         // Arrivals while busy must be ignored.
         if (e_busy && (k == 5 || $urandom_range(0, 9) == 0)) begin
            frog     = W'($urandom);
            arrive_n = 1'b0;
         end
      end
      arrive_n = 1'b1;
      if (valid) begin
         m_data = nxt;
         if (!stale) m_casas = nxt;
      end
      if (win_e) begin
         m_casas = '0;
         m_data  = '0;
         m_level = (m_level + 1) % (1 << LW);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      arrive_n = 1'b1;
      frog     = '0;
      casas    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      run_txn(8'h04, 1'b0, -1);          // first fill
      run_txn(8'h04, 1'b0, -1);          // occupied -> death
      run_txn(8'h00, 1'b0, -1);          // no bit -> death
      run_txn(8'h06, 1'b0, -1);          // two bits -> death
      m_casas = 8'h7F;
      run_txn(8'h80, 1'b0, -1);          // fill last house -> win, hold, clear
      run_txn(8'h01, 1'b1, -1);          // stale readback -> error
      m_casas = 8'h7F;
      run_txn(8'h80, 1'b0, 10);          // reset during win hold
      check("level_after_rst", level, 0);

      for (int t = 0; t < 60; t++) begin
         logic [W-1:0] f;
         if ($urandom_range(0, 2) != 0) f = W'(1) << $urandom_range(0, W - 1);
         else                           f = W'($urandom);
         if ($urandom_range(0, 7) == 0) m_casas = W'($urandom) | 8'h3C;
         run_txn(f, ($urandom_range(0, 9) == 0), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: got=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
